// File: rtl/timers_timer2_cnt.sv
// Timer 2 counting stage: turns the prescaler level into count enables and runs a 16-bit
// auto-reload up-counter with a sticky TF2 flag and a byte-wide SFR port.
module timers_timer2_cnt (
    input  logic        timers_timer2_cnt_clock_i,
    input  logic        timers_timer2_cnt_reset_i_b,
    input  logic        timers_timer2_pdcf_clkdiv_i,
    input  logic [2:0]  timers_sfr_tcon2_dfp_i,
    input  logic        timers_sfr_tcon2_tr2_i,
    input  logic        timers_sfr_tcon2_et2_i,
    input  logic        timers_timer2_cnt_we_i,
    input  logic [1:0]  timers_timer2_cnt_addr_i,
    input  logic [7:0]  timers_timer2_cnt_wdata_i,
    input  logic        timers_timer2_cnt_tf2clr_i,
    output logic [7:0]  timers_timer2_cnt_rdata_o,
    output logic [15:0] timers_timer2_cnt_value_o,
    output logic        timers_timer2_cnt_tf2_o,
    output logic        timers_timer2_cnt_ovf_o,
    output logic        timers_timer2_cnt_irq_o
);

    localparam logic [1:0] ADDR_TL2    = 2'b00;
    localparam logic [1:0] ADDR_TH2    = 2'b01;
    localparam logic [1:0] ADDR_RCAP2L = 2'b10;
    localparam logic [1:0] ADDR_RCAP2H = 2'b11;

    logic        clkdiv_q;
    logic [15:0] count_q, count_d;
    logic [15:0] rcap_q, rcap_d;
    logic        tf2_q, tf2_d;
    logic        ovf_q, ovf_d;
    logic        tick;
    logic        cnt_write;

    // Divide-by-1 holds the prescaler output high, so no edge would ever be seen there.
    assign tick = (timers_sfr_tcon2_dfp_i == 3'b000) ? 1'b1
                : (timers_timer2_pdcf_clkdiv_i & ~clkdiv_q);

    assign cnt_write = timers_timer2_cnt_we_i &&
                       ((timers_timer2_cnt_addr_i == ADDR_TL2) ||
                        (timers_timer2_cnt_addr_i == ADDR_TH2));

    always_comb begin
        count_d = count_q;
        rcap_d  = rcap_q;
        tf2_d   = tf2_q;
        ovf_d   = 1'b0;

        // A count-byte write drops any increment or reload in the same cycle.
        if (cnt_write) begin
            if (timers_timer2_cnt_addr_i == ADDR_TL2)
                count_d[7:0] = timers_timer2_cnt_wdata_i;
            else
                count_d[15:8] = timers_timer2_cnt_wdata_i;
        end else if (timers_sfr_tcon2_tr2_i && tick) begin
            if (count_q == 16'hFFFF) begin
                count_d = rcap_q;
                ovf_d   = 1'b1;
            end else begin
                count_d = count_q + 16'd1;
            end
        end

        if (timers_timer2_cnt_we_i && (timers_timer2_cnt_addr_i == ADDR_RCAP2L))
            rcap_d[7:0] = timers_timer2_cnt_wdata_i;
        if (timers_timer2_cnt_we_i && (timers_timer2_cnt_addr_i == ADDR_RCAP2H))
            rcap_d[15:8] = timers_timer2_cnt_wdata_i;

        if (ovf_d)
            tf2_d = 1'b1;
        else if (timers_timer2_cnt_tf2clr_i)
            tf2_d = 1'b0;
    end

    // clkdiv_q resets high so a prescaler output settling high is not seen as an edge.
    always_ff @(posedge timers_timer2_cnt_clock_i) begin
        if (!timers_timer2_cnt_reset_i_b) begin
            clkdiv_q <= 1'b1;
            count_q  <= 16'h0000;
            rcap_q   <= 16'h0000;
            tf2_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            clkdiv_q <= timers_timer2_pdcf_clkdiv_i;
            count_q  <= count_d;
            rcap_q   <= rcap_d;
            tf2_q    <= tf2_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        timers_timer2_cnt_rdata_o = count_q[7:0];
        case (timers_timer2_cnt_addr_i)
            ADDR_TL2:    timers_timer2_cnt_rdata_o = count_q[7:0];
            ADDR_TH2:    timers_timer2_cnt_rdata_o = count_q[15:8];
            ADDR_RCAP2L: timers_timer2_cnt_rdata_o = rcap_q[7:0];
            ADDR_RCAP2H: timers_timer2_cnt_rdata_o = rcap_q[15:8];
            default:     timers_timer2_cnt_rdata_o = count_q[7:0];
        endcase
    end

    assign timers_timer2_cnt_value_o = count_q;
    assign timers_timer2_cnt_tf2_o   = tf2_q;
    assign timers_timer2_cnt_ovf_o   = ovf_q;
    assign timers_timer2_cnt_irq_o   = tf2_q & timers_sfr_tcon2_et2_i;

endmodule
